// File: rtl/smash_pkg.sv
// Shared definitions for the SMASH router output stage: flit type codes,
// type-field placement and the output arbiter state encoding.
package smash_pkg;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_TAIL   = 2'b01;
    localparam logic [1:0] FLIT_HEAD   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    // Type field positions as offsets below the flit width: bits [W-1:W-2].
    localparam int FLIT_TYPE_MSB = 1;
    localparam int FLIT_TYPE_LSB = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic is_start(input logic [1:0] ftype);
        return (ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE);
    endfunction

    function automatic logic is_last(input logic [1:0] ftype);
        return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/smash_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping at N_PORTS. Outputs are zero when nothing requests.
module smash_rr_arbiter #(
    parameter int N_PORTS = 4
) (
    input  logic [N_PORTS-1:0]         req,
    input  logic [$clog2(N_PORTS)-1:0] ptr,
    output logic [N_PORTS-1:0]         gnt,
    output logic [$clog2(N_PORTS)-1:0] index
);
    localparam int PTR_W = $clog2(N_PORTS);

    always_comb begin : pick
        logic             found;
        logic [PTR_W-1:0] cand;
        gnt   = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N_PORTS);
            if (!found && req[cand]) begin
                found      = 1'b1;
                gnt[cand]  = 1'b1;
                index      = cand;
            end
        end
    end

endmodule

// File: rtl/smash_output_arbiter.sv
// Wormhole output-port arbiter: locks one input FIFO per packet (head to tail),
// steering its flits straight into the shared downstream FIFO.
module smash_output_arbiter
    import smash_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int DATA_SIZE = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N_PORTS-1:0]           i_empty,
    input  logic [N_PORTS*DATA_SIZE-1:0] i_data,
    output logic [N_PORTS-1:0]           o_read,
    output logic [DATA_SIZE-1:0]         o_data,
    output logic                         o_write,
    input  logic                         i_full,
    output logic [N_PORTS-1:0]           o_grant,
    output logic                         o_busy,
    output logic                         o_proto_err
);
    localparam int PTR_W    = $clog2(N_PORTS);
    localparam int TYPE_LSB = DATA_SIZE - FLIT_TYPE_LSB;
    localparam int TYPE_W   = FLIT_TYPE_LSB - FLIT_TYPE_MSB + 1;

    state_t               state_q, state_d;
    logic [N_PORTS-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 proto_err_q, proto_err_d;

    logic [N_PORTS-1:0]   req;
    logic [N_PORTS-1:0]   bad_front;
    logic [N_PORTS-1:0]   arb_gnt;
    logic [PTR_W-1:0]     arb_idx;
    logic [DATA_SIZE-1:0] front_g;
    logic [TYPE_W-1:0]    front_g_type;
    logic                 xfer;

    // A non-empty port whose front is mid-packet can never start a packet.
    always_comb begin : classify
        logic [TYPE_W-1:0] ftype;
        req       = '0;
        bad_front = '0;
        ftype     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            ftype        = i_data[k*DATA_SIZE + TYPE_LSB +: TYPE_W];
            req[k]       = !i_empty[k] && is_start(ftype);
            bad_front[k] = !i_empty[k] && !is_start(ftype);
        end
    end

    smash_rr_arbiter #(
        .N_PORTS (N_PORTS)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .index (arb_idx)
    );

    always_comb begin : grant_mux
        front_g = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (grant_q[k]) front_g = i_data[k*DATA_SIZE +: DATA_SIZE];
        end
    end

    assign front_g_type = front_g[TYPE_LSB +: TYPE_W];
    assign xfer = (state_q == ST_LOCKED) && |(grant_q & ~i_empty) && !i_full;

    always_comb begin : fsm
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        proto_err_d = proto_err_q;
        o_read      = '0;
        o_write     = 1'b0;
        o_data      = '0;
        case (state_q)
            ST_IDLE: begin
                if (|bad_front) proto_err_d = 1'b1;
                if (|req) begin
                    state_d = ST_LOCKED;
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                end
            end
            ST_LOCKED: begin
                o_data = front_g;
                if (xfer) begin
                    o_read  = grant_q;
                    o_write = 1'b1;
                    if (is_last(front_g_type)) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        // Move past the winner so it cannot immediately win again.
                        rr_ptr_d = (gidx_q == PTR_W'(N_PORTS - 1)) ? '0 : gidx_q + PTR_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_busy      = (state_q == ST_LOCKED);
    assign o_proto_err = proto_err_q;

endmodule

// File: tb/tb_smash_output_arbiter.sv
// Scoreboard bench for smash_output_arbiter: modelled input FIFOs, directed
// packets, expected downstream flits queued up front and checked on each write.
module tb_smash_output_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;

    logic             clk;
    logic             i_rst_n;
    logic [NP-1:0]    i_empty;
    logic [NP*DW-1:0] i_data;
    logic [NP-1:0]    o_read;
    logic [DW-1:0]    o_data;
    logic             o_write;
    logic             i_full;
    logic [NP-1:0]    o_grant;
    logic             o_busy;
    logic             o_proto_err;

    smash_output_arbiter #(
        .N_PORTS   (NP),
        .DATA_SIZE (DW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_empty     (i_empty),
        .i_data      (i_data),
        .o_read      (o_read),
        .o_data      (o_data),
        .o_write     (o_write),
        .i_full      (i_full),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_proto_err (o_proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total;
    int            bad;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem[NP][64];
    int            wp[NP];
    int            rp[NP];
    logic [NP-1:0] rd_n;

    localparam logic [1:0] BODY = 2'b00, TAIL = 2'b01, HEAD = 2'b10, SNGL = 2'b11;

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input int p, input int s);
        return {t, 18'h0, 4'(p), 8'(s)};
    endfunction

    task automatic refresh();
        for (int k = 0; k < NP; k++) begin
            i_empty[k]        = (wp[k] == rp[k]);
            i_data[k*DW +: DW] = (wp[k] == rp[k]) ? '0 : mem[k][rp[k]];
        end
    endtask

    task automatic push(input int p, input logic [DW-1:0] f);
        mem[p][wp[p]] = f;
        wp[p]++;
    endtask

    task automatic clear_fifos();
        for (int k = 0; k < NP; k++) begin
            wp[k] = 0;
            rp[k] = 0;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string nm, input int max, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(posedge clk);
            #3;
            n++;
        end
        check({"drain_", nm}, 32'(exp_q.size()), 32'd0);
    endtask

    // Input FIFO model: pop whatever the DUT strobed in the previous cycle.
    always @(posedge clk) begin
        #1;
        if (i_rst_n) begin
            for (int k = 0; k < NP; k++) if (rd_n[k]) rp[k]++;
        end
        refresh();
    end

    // Monitor: scoreboard pops on every downstream write, plus strobe invariants.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        rd_n = o_read;
        if (i_rst_n) begin
            total++;
            if (o_write && i_full) begin
                bad++;
                $display("FAIL write_while_full: o_write=%0b i_full=%0b", o_write, i_full);
            end
            total++;
            if (o_read !== (o_write ? o_grant : '0)) begin
                bad++;
                $display("FAIL read_strobe: o_read=%b expected %b", o_read, (o_write ? o_grant : '0));
            end
            total++;
            if (!o_busy && o_data !== '0) begin
                bad++;
                $display("FAIL idle_data: o_data=%0h expected 0", o_data);
            end
            if (o_write) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: o_data=%0h with empty scoreboard", o_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_data !== e) begin
                        bad++;
                        $display("FAIL flit_data: got %0h expected %0h", o_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        i_rst_n = 1'b0;
        i_full  = 1'b0;
        i_data  = '0;
        i_empty = '1;
        rd_n    = '0;
        clear_fifos();
        refresh();
        #3;
        check("rst_busy",  32'(o_busy), 32'd0);
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_read",  32'(o_read), 32'd0);
        check("rst_write", 32'(o_write), 32'd0);
        check("rst_data",  o_data, 32'd0);
        check("rst_err",   32'(o_proto_err), 32'd0);
        step();
        step();
        i_rst_n = 1'b1;

        // Round-robin from ptr 0: order 0,1,2,3 then port 0's second packet.
        step();
        for (int p = 0; p < NP; p++) push(p, mk(SNGL, p, 1));
        push(0, mk(SNGL, 0, 2));
        refresh();
        for (int p = 0; p < NP; p++) exp_q.push_back(mk(SNGL, p, 1));
        exp_q.push_back(mk(SNGL, 0, 2));
        drain("rr", 40, n);
        check("rr_cycles", 32'(n), 32'd10);
        check("rr_idle", 32'(o_busy), 32'd0);

        // Single three-flit packet on port 1 (ptr now 1).
        step();
        push(1, mk(HEAD, 1, 3));
        push(1, mk(BODY, 1, 4));
        push(1, mk(TAIL, 1, 5));
        refresh();
        exp_q.push_back(mk(HEAD, 1, 3));
        exp_q.push_back(mk(BODY, 1, 4));
        exp_q.push_back(mk(TAIL, 1, 5));
        step();
        #1;
        check("single_grant", 32'(o_grant), 32'h2);
        check("single_busy",  32'(o_busy), 32'd1);
        check("single_first", 32'(o_write), 32'd1);
        drain("single", 20, n);
        check("single_cycles", 32'(n), 32'd3);
        check("single_idle_grant", 32'(o_grant), 32'd0);

        // Backpressure on port 3 for three cycles after the head.
        step();
        push(3, mk(HEAD, 3, 6));
        push(3, mk(BODY, 3, 7));
        push(3, mk(BODY, 3, 8));
        push(3, mk(TAIL, 3, 9));
        refresh();
        exp_q.push_back(mk(HEAD, 3, 6));
        exp_q.push_back(mk(BODY, 3, 7));
        exp_q.push_back(mk(BODY, 3, 8));
        exp_q.push_back(mk(TAIL, 3, 9));
        step();
        step();
        i_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_write", 32'(o_write), 32'd0);
            check("bp_read",  32'(o_read), 32'd0);
            check("bp_grant", 32'(o_grant), 32'h8);
            step();
        end
        i_full = 1'b0;
        drain("bp", 20, n);
        check("bp_left", 32'(exp_q.size()), 32'd0);

        // Source starvation on port 1 while port 0 waits with a head.
        step();
        push(1, mk(HEAD, 1, 10));
        push(1, mk(BODY, 1, 11));
        refresh();
        exp_q.push_back(mk(HEAD, 1, 10));
        exp_q.push_back(mk(BODY, 1, 11));
        exp_q.push_back(mk(BODY, 1, 12));
        exp_q.push_back(mk(TAIL, 1, 13));
        exp_q.push_back(mk(HEAD, 0, 14));
        exp_q.push_back(mk(TAIL, 0, 15));
        step();
        push(0, mk(HEAD, 0, 14));
        push(0, mk(TAIL, 0, 15));
        refresh();
        step();
        step();
        #1;
        check("starve_grant0", 32'(o_grant), 32'h2);
        check("starve_write0", 32'(o_write), 32'd0);
        step();
        #1;
        check("starve_grant1", 32'(o_grant), 32'h2);
        check("starve_busy1",  32'(o_busy), 32'd1);
        step();
        push(1, mk(BODY, 1, 12));
        push(1, mk(TAIL, 1, 13));
        refresh();
        drain("starve", 30, n);

        // Protocol error: stray BODY at the front of port 2 while idle.
        step();
        push(2, mk(BODY, 2, 16));
        refresh();
        step();
        #1;
        check("perr_set",   32'(o_proto_err), 32'd1);
        check("perr_grant", 32'(o_grant), 32'd0);
        check("perr_busy",  32'(o_busy), 32'd0);
        step();
        step();
        #1;
        check("perr_sticky", 32'(o_proto_err), 32'd1);
        step();
        push(0, mk(SNGL, 0, 17));
        refresh();
        exp_q.push_back(mk(SNGL, 0, 17));
        drain("perr", 20, n);
        check("perr_still", 32'(o_proto_err), 32'd1);

        // Reset mid-packet on port 2, then ptr must be back at 0.
        step();
        i_rst_n = 1'b0;
        clear_fifos();
        refresh();
        step();
        i_rst_n = 1'b1;
        step();
        push(2, mk(HEAD, 2, 18));
        push(2, mk(BODY, 2, 19));
        refresh();
        exp_q.push_back(mk(HEAD, 2, 18));
        step();
        step();
        #1;
        check("mid_grant", 32'(o_grant), 32'h4);
        check("mid_write", 32'(o_write), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("mrst_busy",  32'(o_busy), 32'd0);
        check("mrst_grant", 32'(o_grant), 32'd0);
        check("mrst_read",  32'(o_read), 32'd0);
        check("mrst_write", 32'(o_write), 32'd0);
        check("mrst_data",  o_data, 32'd0);
        check("mrst_err",   32'(o_proto_err), 32'd0);
        clear_fifos();
        push(1, mk(SNGL, 1, 20));
        push(0, mk(SNGL, 0, 21));
        refresh();
        check("mrst_scoreboard", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(mk(SNGL, 0, 21));
        exp_q.push_back(mk(SNGL, 1, 20));
        step();
        i_rst_n = 1'b1;
        step();
        #1;
        check("post_rst_grant", 32'(o_grant), 32'h1);
        drain("post_rst", 20, n);
        check("post_rst_idle", 32'(o_busy), 32'd0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
